axi4_mem_slave_p: RTL and testbench
===================================

# axi4_mem_slave_p

Parametrised AXI4 full-protocol memory slave: the next-generation behavioural/synthesizable memory model used as the DDR stand-in behind the AXI DMA master. Compared with the fixed 32-bit single-mode predecessor, it generalises data width, depth and ID width. It also adds FIXED/INCR/WRAP bursts, ID echo, out-of-range and size error responses, and optional byte-strobe writes. Independent read and write FSMs allow a read burst and a write burst to run concurrently.

## Interface
- DATA_W, 32: data bus width in bits; one of 32, 64, 128.
- ADDR_W, 32: byte address width.
- ID_W, 4: AXI ID width.
- DEPTH, 1024: memory size in DATA_W-bit words.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_W/ADDR_W/8/3/2  write address; AWVALID in 1, AWREADY out 1.
- WDATA/WSTRB/WLAST  in  DATA_W/DATA_W/8/1  write data; WVALID in 1, WREADY out 1.
- BID/BRESP  out  ID_W/2  write response; BVALID out 1, BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID_W/ADDR_W/8/3/2  read address; ARVALID in 1, ARREADY out 1.
- RID/RDATA/RRESP/RLAST  out  ID_W/DATA_W/2/1  read data; RVALID out 1, RREADY in 1.

## Operation
- Memory: DEPTH words, initialised word[i] = i (zero-extended). Word index = byte address >> log2(DATA_W/8).
- Beat address: FIXED repeats the start address. INCR adds DATA_W/8 per beat. WRAP wraps within an aligned block of (LEN+1)*DATA_W/8 bytes.
- WRAP with LEN not in {1,3,7,15} is treated as INCR.
- Read FSM R_IDLE -> R_DATA -> R_IDLE.
  - R_IDLE: ARREADY=1. On AR handshake, latch ID, address, LEN, SIZE and BURST; ARREADY drops; go to R_DATA.
  - R_DATA: RVALID=1, RID = latched ID. RLAST=1 on beat LEN (0-based). The beat counter advances only on an R handshake.
  - Last beat accepted: return to R_IDLE.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE.
  - W_IDLE: AWREADY=1.
  - W_DATA: WREADY=1. Each W handshake writes the beat address and advances the counter.
  - W handshake with WLAST: go to W_RESP.
  - W_RESP: BVALID=1, BID = latched ID. On B handshake, return to W_IDLE.
- Errors, BRESP/RRESP:
  - SIZE != log2(DATA_W/8): SLVERR (2'b10) for the whole burst; no memory write; RDATA=0.
  - Beat word index >= DEPTH: DECERR (2'b11) for reads, per beat with RDATA=0. For writes, that beat is dropped and the final BRESP is DECERR.
  - WLAST on a beat other than LEN: write ends at WLAST; BRESP=SLVERR unless DECERR already applies (DECERR has priority).
  - Otherwise the response is OKAY.
- Arithmetic: beat counter 8 bits. Address math at ADDR_W; wrap beyond 2^ADDR_W is modulo.
- Same-word read and write in the same cycle: the read returns the old data (read-first).

## Timing
- Reset values, all outputs: ARREADY=AWREADY=WREADY=0, RVALID=BVALID=RLAST=0, RDATA=0, RID=BID=0, RRESP=BRESP=0.
- ARREADY/AWREADY rise the first cycle after ARESET deasserts.
- AR handshake at cycle T: first RVALID at T+1. With RREADY held high, one beat per cycle, and ARREADY returns at (last beat)+1.
- RDATA/RID/RRESP/RLAST are registered and held stable while RVALID && !RREADY.
- AW handshake at T: WREADY at T+1. Last W handshake at T2: BVALID at T2+1. AWREADY returns the cycle after the B handshake.
- Early WVALID is permitted: W beats are not consumed until W_DATA.
- Read and write paths are fully independent; there is no arbitration stall.
- ARESET mid-burst: both FSMs go to IDLE and all outputs return to reset values immediately (async). Memory contents are preserved and no partial-burst response is issued.

## Configuration
- AXI_MEM_WSTRB_EN defined: each byte lane is written only where its WSTRB bit is 1.
- Not defined: WSTRB is ignored and every accepted beat writes the full word.

## Test plan
- DATA_W=32. INCR read: ARADDR=0x40, ARLEN=3 -> RDATA 16,17,18,19; RLAST on the 4th beat; RRESP=OKAY; RID echoes ARID=5.
- WRAP read: ARADDR=0x38, ARLEN=3, DATA_W=32 -> words 14,15,12,13.
- INCR write: AWADDR=0x100, AWLEN=1, data 0xA5A5A5A5/0x5A5A5A5A. Then read back -> same values. BRESP=OKAY, BID=AWID.
- With AXI_MEM_WSTRB_EN: write 0xFFFFFFFF WSTRB=4'b0011 to word 8 -> readback 0x0000FFFF. Without the macro -> 0xFFFFFFFF.
- Errors:
  - Read ARADDR=DEPTH*4, ARLEN=0 -> RRESP=DECERR, RDATA=0.
  - AWSIZE=1 on DATA_W=32 -> BRESP=SLVERR and memory unchanged.
  - WLAST on beat 1 of AWLEN=3 -> BRESP=SLVERR.
- RREADY toggled 1/0 during a 4-beat read -> RDATA stable while stalled. A concurrent write burst completes.
- ARESET pulsed mid-read -> RVALID=0 the same cycle; ARREADY=1 one cycle after release; the next read returns the correct data.

Source files
------------

// File: rtl/axi4_mem_slave_p.sv
// AXI4 memory slave (FIXED/INCR/WRAP, ID echo, SLVERR/DECERR); byte strobes when AXI_MEM_WSTRB_EN is defined.
// Latency: first R beat one cycle after AR, then one beat per cycle; BVALID one cycle after the last W beat.
// Backpressure: R outputs held while RREADY is low, B held until BREADY; read and write FSMs never stall each other.
module axi4_mem_slave_p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DEPTH  = 1024
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [2:0] SIZE_OK = 3'(OFF);
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // Words are stored XORed with their index so that an all-zero power-up image reads as word[i] = i.
    logic [DATA_W-1:0] mem_q [DEPTH];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] mask;
        logic [ADDR_W-1:0] inc;
        mask = ((ADDR_W'(len) + ADDR_W'(1)) << OFF) - ADDR_W'(1);
        inc  = a + ADDR_W'(STRB_W);
        next_addr = inc;
        if (burst == 2'b00)
            next_addr = a;
        else if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            next_addr = (a & ~mask) | (inc & mask);
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >> OFF) < ADDR_W'(DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'(a >> OFF);
    endfunction

    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        return mem_q[word_idx(a)] ^ DATA_W'(word_idx(a));
    endfunction

    r_state_t          r_state_q, r_state_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d, r_beat_addr;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [1:0]        r_burst_q, r_burst_d, rresp_q, rresp_d;
    logic              r_serr_q, r_serr_d, r_serr_cur, r_load;
    logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    w_state_t          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d, bid_q, bid_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [1:0]        w_burst_q, w_burst_d, bresp_q, bresp_d;
    logic              w_serr_q, w_serr_d, w_dec_q, w_dec_d, dec_now, mem_we;
    logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [DATA_W-1:0] wr_word;

    always_comb begin
        r_state_d = r_state_q;  rid_d = rid_q;         r_addr_d = r_addr_q;
        r_len_d   = r_len_q;    r_cnt_d = r_cnt_q;     r_burst_d = r_burst_q;
        r_serr_d  = r_serr_q;   arready_d = arready_q; rvalid_d = rvalid_q;
        rlast_d   = rlast_q;    rdata_d = rdata_q;     rresp_d = rresp_q;
        r_beat_addr = r_addr_q;
        r_load      = 1'b0;
        r_serr_cur  = r_serr_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    rid_d       = ARID;
                    r_len_d     = ARLEN;
                    r_burst_d   = ARBURST;
                    r_serr_d    = (ARSIZE != SIZE_OK);
                    r_serr_cur  = (ARSIZE != SIZE_OK);
                    r_cnt_d     = 8'd0;
                    r_beat_addr = ARADDR;
                    r_load      = 1'b1;
                    rlast_d     = (ARLEN == 8'd0);
                    arready_d   = 1'b0;
                    rvalid_d    = 1'b1;
                    r_state_d   = R_DATA;
                end
            end
            default: begin
                if (RREADY) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_beat_addr = next_addr(r_addr_q, r_len_q, r_burst_q);
                        r_load      = 1'b1;
                        r_cnt_d     = r_cnt_q + 8'd1;
                        rlast_d     = (r_cnt_q + 8'd1 == r_len_q);
                    end
                end
            end
        endcase
        // Memory is sampled before this edge's write lands, giving read-first on collisions.
        if (r_load) begin
            r_addr_d = r_beat_addr;
            if (r_serr_cur) begin
                rdata_d = '0;
                rresp_d = SLVERR;
            end else if (!in_range(r_beat_addr)) begin
                rdata_d = '0;
                rresp_d = DECERR;
            end else begin
                rdata_d = mem_rd(r_beat_addr);
                rresp_d = OKAY;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;  w_id_d = w_id_q;       w_addr_d = w_addr_q;
        w_len_d   = w_len_q;    w_cnt_d = w_cnt_q;     w_burst_d = w_burst_q;
        w_serr_d  = w_serr_q;   w_dec_d = w_dec_q;     awready_d = awready_q;
        wready_d  = wready_q;   bvalid_d = bvalid_q;   bid_d = bid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        dec_now   = w_dec_q;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (AWVALID && awready_q) begin
                    w_id_d    = AWID;
                    w_addr_d  = AWADDR;
                    w_len_d   = AWLEN;
                    w_burst_d = AWBURST;
                    w_serr_d  = (AWSIZE != SIZE_OK);
                    w_dec_d   = 1'b0;
                    w_cnt_d   = 8'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID && wready_q) begin
                    mem_we   = !w_serr_q && in_range(w_addr_q);
                    dec_now  = w_dec_q || (!w_serr_q && !in_range(w_addr_q));
                    w_dec_d  = dec_now;
                    w_addr_d = next_addr(w_addr_q, w_len_q, w_burst_q);
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (WLAST) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bid_d     = w_id_q;
                        w_state_d = W_RESP;
                        if (w_serr_q)                bresp_d = SLVERR;
                        else if (dec_now)            bresp_d = DECERR;
                        else if (w_cnt_q != w_len_q) bresp_d = SLVERR;
                        else                         bresp_d = OKAY;
                    end
                end
            end
            default: begin
                if (BREADY) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

`ifdef AXI_MEM_WSTRB_EN
    always_comb begin
        wr_word = mem_rd(w_addr_q);
        for (int b = 0; b < STRB_W; b++)
            if (WSTRB[b]) wr_word[8*b +: 8] = WDATA[8*b +: 8];
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^WSTRB;
    assign wr_word      = WDATA;
`endif

    // No reset on the array: contents survive ARESET.
    always_ff @(posedge ACLK) begin
        if (mem_we) mem_q[word_idx(w_addr_q)] <= wr_word ^ DATA_W'(word_idx(w_addr_q));
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;  rid_q <= '0;        r_addr_q <= '0;     r_len_q <= '0;
            r_cnt_q <= '0;        r_burst_q <= '0;    r_serr_q <= 1'b0;   arready_q <= 1'b0;
            rvalid_q <= 1'b0;     rlast_q <= 1'b0;    rdata_q <= '0;      rresp_q <= '0;
            w_state_q <= W_IDLE;  w_id_q <= '0;       w_addr_q <= '0;     w_len_q <= '0;
            w_cnt_q <= '0;        w_burst_q <= '0;    w_serr_q <= 1'b0;   w_dec_q <= 1'b0;
            awready_q <= 1'b0;    wready_q <= 1'b0;   bvalid_q <= 1'b0;   bid_q <= '0;
            bresp_q <= '0;
        end else begin
            r_state_q <= r_state_d; rid_q <= rid_d;         r_addr_q <= r_addr_d;   r_len_q <= r_len_d;
            r_cnt_q <= r_cnt_d;     r_burst_q <= r_burst_d; r_serr_q <= r_serr_d;   arready_q <= arready_d;
            rvalid_q <= rvalid_d;   rlast_q <= rlast_d;     rdata_q <= rdata_d;     rresp_q <= rresp_d;
            w_state_q <= w_state_d; w_id_q <= w_id_d;       w_addr_q <= w_addr_d;   w_len_q <= w_len_d;
            w_cnt_q <= w_cnt_d;     w_burst_q <= w_burst_d; w_serr_q <= w_serr_d;   w_dec_q <= w_dec_d;
            awready_q <= awready_d; wready_q <= wready_d;   bvalid_q <= bvalid_d;   bid_q <= bid_d;
            bresp_q <= bresp_d;
        end
    end

    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;
    assign RRESP   = rresp_q;
    assign RLAST   = rlast_q;
    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;
endmodule

// File: tb/tb_axi4_mem_slave_p.sv
// Scoreboard bench for axi4_mem_slave_p: directed cases followed by randomized bursts against a memory model.
module tb_axi4_mem_slave_p;
    localparam int DATA_W = 32, ADDR_W = 32, ID_W = 4, DEPTH = 1024;

    logic              ACLK = 1'b0, ARESET = 1'b1;
    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [DATA_W/8-1:0] WSTRB;

    axi4_mem_slave_p #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial forever #5 ACLK = ~ACLK;

    typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;

    int          vectors = 0, miscompares = 0;
    rbeat_t      r_exp[$];
    bexp_t       b_exp[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] wdat_buf [256];
    logic [3:0]  wstrb_buf [256];
    int          rmode = 0, bmode = 0;
    logic        r_stalled = 1'b0, r_hold_last;
    logic [31:0] r_hold_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference addressing: whole-burst arithmetic from the start address, modulo 2^32.
    function automatic longint beat_addr(input longint start, input int len, input int burst, input int k);
        longint blk, base;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            blk  = longint'(len + 1) * 4;
            base = start - (start % blk);
            return base + ((start - base) + 4 * longint'(k)) % blk;
        end
        return (start + 4 * longint'(k)) % (longint'(1) << 32);
    endfunction

    task automatic issue_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [2:0] size, input int burst);
        rbeat_t e;
        longint a, s;
        logic   hs;
        int     n;
        s = longint'(addr);
        for (int k = 0; k <= len; k++) begin
            a      = beat_addr(s, len, burst, k);
            e.id   = id;
            e.last = (k == len);
            if (size != 3'd2)           begin e.data = 32'h0; e.resp = 2'b10; end
            else if (a / 4 >= DEPTH)    begin e.data = 32'h0; e.resp = 2'b11; end
            else                        begin e.data = mdl[int'(a / 4)]; e.resp = 2'b00; end
            r_exp.push_back(e);
        end
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = 2'(burst); ARVALID = 1'b1;
        hs = 1'b0; n = 0;
        while (!hs && n < 200) begin
            @(negedge ACLK); hs = ARREADY;
            @(posedge ACLK); #1; n++;
        end
        ARVALID = 1'b0;
        chk("ar_handshake", hs, 1);
        @(negedge ACLK);
        chk("rvalid_after_ar", RVALID, 1);
    endtask

    task automatic wait_r_done();
        int n = 0;
        while (r_exp.size() != 0 && n < 3000) begin @(negedge ACLK); n++; end
        chk("r_drain", r_exp.size(), 0);
        r_exp.delete();
        @(posedge ACLK); #1;
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input logic [2:0] size, input int burst, input int nbeats);
        bexp_t  e;
        longint a, s;
        logic   dec, awhs, whs, aw_done;
        int     beat, n;
        s = longint'(addr); dec = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            a = beat_addr(s, len, burst, k);
            if (size == 3'd2) begin
                if (a / 4 >= DEPTH) dec = 1'b1;
                else begin
`ifdef AXI_MEM_WSTRB_EN
                    for (int b = 0; b < 4; b++)
                        if (wstrb_buf[k][b]) mdl[int'(a / 4)][8*b +: 8] = wdat_buf[k][8*b +: 8];
`else
                    mdl[int'(a / 4)] = wdat_buf[k];
`endif
                end
            end
        end
        e.id = id;
        if (size != 3'd2)           e.resp = 2'b10;
        else if (dec)               e.resp = 2'b11;
        else if (nbeats - 1 != len) e.resp = 2'b10;
        else                        e.resp = 2'b00;
        b_exp.push_back(e);
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = 2'(burst); AWVALID = 1'b1;
        beat = 0; WDATA = wdat_buf[0]; WSTRB = wstrb_buf[0]; WLAST = (nbeats == 1); WVALID = 1'b1;
        aw_done = 1'b0; n = 0;
        while ((!aw_done || beat < nbeats) && n < 500) begin
            @(negedge ACLK); awhs = AWVALID && AWREADY; whs = WVALID && WREADY;
            @(posedge ACLK); #1; n++;
            if (awhs) begin AWVALID = 1'b0; aw_done = 1'b1; end
            if (whs) begin
                beat++;
                WVALID = 1'b0;
                if (beat < nbeats) begin
                    WDATA = wdat_buf[beat]; WSTRB = wstrb_buf[beat]; WLAST = (beat == nbeats - 1);
                    WVALID = ($urandom_range(0, 3) != 0);
                end
            end else if (beat < nbeats) WVALID = 1'b1;
        end
        AWVALID = 1'b0; WVALID = 1'b0; WLAST = 1'b0;
        chk("w_beats_taken", beat, nbeats);
        n = 0;
        while (b_exp.size() != 0 && n < 500) begin @(negedge ACLK); n++; end
        chk("b_drain", b_exp.size(), 0);
        b_exp.delete();
        @(posedge ACLK); #1;
    endtask

    initial begin
        RREADY = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            case (rmode)
                0: RREADY = 1'b1;
                1: RREADY = !RREADY;
                2: RREADY = 1'($urandom_range(0, 1));
                default: RREADY = 1'b0;
            endcase
        end
    end

    initial begin
        BREADY = 1'b1;
        forever begin
            @(posedge ACLK); #1;
            BREADY = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    initial begin
        rbeat_t e;
        forever begin
            @(negedge ACLK);
            if (ARESET) r_stalled = 1'b0;
            else begin
                if (r_stalled) begin
                    chk("r_hold_valid", RVALID, 1);
                    chk("r_hold_data", RDATA, r_hold_data);
                    chk("r_hold_last", RLAST, r_hold_last);
                end
                if (RVALID && RREADY) begin
                    if (r_exp.size() == 0) chk("r_unexpected_beat", RVALID, 0);
                    else begin
                        e = r_exp.pop_front();
                        chk("rid", RID, e.id);
                        chk("rdata", RDATA, e.data);
                        chk("rresp", RRESP, e.resp);
                        chk("rlast", RLAST, e.last);
                    end
                end
                r_stalled   = RVALID && !RREADY;
                r_hold_data = RDATA;
                r_hold_last = RLAST;
            end
        end
    end

    initial begin
        bexp_t e;
        forever begin
            @(negedge ACLK);
            if (!ARESET && BVALID && BREADY) begin
                if (b_exp.size() == 0) chk("b_unexpected", BVALID, 0);
                else begin
                    e = b_exp.pop_front();
                    chk("bid", BID, e.id);
                    chk("bresp", BRESP, e.resp);
                end
            end
        end
    end

    initial begin
        int len, nb, burst;
        logic [31:0] addr;
        logic [2:0]  size;
        for (int i = 0; i < DEPTH; i++) mdl[i] = 32'(i);
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        #2;
        chk("rst_arready", ARREADY, 0); chk("rst_awready", AWREADY, 0); chk("rst_wready", WREADY, 0);
        chk("rst_rvalid", RVALID, 0);   chk("rst_bvalid", BVALID, 0);   chk("rst_rlast", RLAST, 0);
        chk("rst_rdata", RDATA, 0);     chk("rst_rid", RID, 0);         chk("rst_bid", BID, 0);
        chk("rst_rresp", RRESP, 0);     chk("rst_bresp", BRESP, 0);
        @(posedge ACLK); #1; ARESET = 1'b0;
        @(negedge ACLK); chk("arready_pre_edge", ARREADY, 0);
        @(negedge ACLK); chk("arready_post_rst", ARREADY, 1); chk("awready_post_rst", AWREADY, 1);
        @(posedge ACLK); #1;

        issue_read(4'd5, 32'h40, 3, 3'd2, 1); wait_r_done();
        issue_read(4'd6, 32'h38, 3, 3'd2, 2); wait_r_done();

        wdat_buf[0] = 32'hA5A5A5A5; wdat_buf[1] = 32'h5A5A5A5A; wstrb_buf[0] = 4'hF; wstrb_buf[1] = 4'hF;
        do_write(4'd7, 32'h100, 1, 3'd2, 1, 2);
        issue_read(4'd1, 32'h100, 1, 3'd2, 1); wait_r_done();

        wdat_buf[0] = 32'hFFFFFFFF; wstrb_buf[0] = 4'b0011;
        do_write(4'd2, 32'h20, 0, 3'd2, 1, 1);
        issue_read(4'd2, 32'h20, 0, 3'd2, 1); wait_r_done();

        issue_read(4'd3, 32'(DEPTH * 4), 0, 3'd2, 1); wait_r_done();

        wdat_buf[0] = 32'hDEADBEEF; wstrb_buf[0] = 4'hF;
        do_write(4'd4, 32'h50, 0, 3'd1, 1, 1);
        issue_read(4'd4, 32'h50, 0, 3'd2, 1); wait_r_done();

        wdat_buf[0] = 32'h11111111; wdat_buf[1] = 32'h22222222;
        do_write(4'd8, 32'h200, 3, 3'd2, 1, 2);
        issue_read(4'd8, 32'h200, 3, 3'd2, 1); wait_r_done();

        for (int k = 0; k < 8; k++) begin wdat_buf[k] = $urandom; wstrb_buf[k] = 4'hF; end
        rmode = 1;
        fork
            begin issue_read(4'd3, 32'h40, 3, 3'd2, 1); wait_r_done(); end
            do_write(4'd9, 32'h800, 7, 3'd2, 1, 8);
        join
        rmode = 0;
        issue_read(4'd9, 32'h800, 7, 3'd2, 1); wait_r_done();

        rmode = 3;
        issue_read(4'd2, 32'h80, 3, 3'd2, 1);
        @(posedge ACLK); #1; ARESET = 1'b1; #1;
        chk("midrst_rvalid", RVALID, 0); chk("midrst_arready", ARREADY, 0); chk("midrst_rdata", RDATA, 0);
        r_exp.delete();
        @(posedge ACLK); #1; ARESET = 1'b0; rmode = 0;
        @(negedge ACLK); chk("arready_rel_cycle", ARREADY, 0);
        @(negedge ACLK); chk("arready_rel_next", ARREADY, 1);
        @(posedge ACLK); #1;
        issue_read(4'd2, 32'h80, 3, 3'd2, 1); wait_r_done();

        rmode = 2; bmode = 1;
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 5))
                0: len = 0; 1: len = 1; 2: len = 3; 3: len = 7; 4: len = 15;
                default: len = $urandom_range(0, 20);
            endcase
            burst = $urandom_range(0, 2);
            size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
            case ($urandom_range(0, 9))
                0: addr = 32'(DEPTH * 4 - 8 + 4 * $urandom_range(0, 3));
                1: addr = 32'hFFFF_FFF0;
                default: addr = 32'($urandom_range(0, DEPTH - 1) * 4);
            endcase
            if ($urandom_range(0, 1) == 0) begin
                issue_read(4'($urandom), addr, len, size, burst); wait_r_done();
            end else begin
                nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, len + 1) : len + 1;
                for (int k = 0; k < nb; k++) begin wdat_buf[k] = $urandom; wstrb_buf[k] = 4'($urandom); end
                do_write(4'($urandom), addr, len, size, burst, nb);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
